// File: rtl/vpu_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vpu_stream_ctrl
// Brief    : Vector command sequencer feeding the VPU ALU stage. Streams
//            element pairs from a dual-read buffer (1-cycle read latency),
//            presents them to the ALU, registers each result and writes it
//            back, then pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module vpu_stream_ctrl #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    // command interface
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_opcode,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [ADDR_W-1:0] cmd_src0,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_dst,
    // buffer read ports
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    input  logic [DATA_W-1:0] rd_data0,
    input  logic [DATA_W-1:0] rd_data1,
    // ALU interface
    output logic              alu_start,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_operand0,
    output logic [DATA_W-1:0] alu_operand1,
    input  logic [DATA_W-1:0] alu_result,
    // buffer write port
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    // status
    output logic              done,
    output logic              busy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    // command context
    logic [OP_W-1:0]   r_op;
    logic [LEN_W-1:0]  r_remain;     // reads still to issue after the current one
    logic              r_drain;      // second DRAIN cycle marker
    logic [ADDR_W-1:0] r_rd_addr0;
    logic [ADDR_W-1:0] r_rd_addr1;
    logic [ADDR_W-1:0] r_rd_dst;     // destination address paired with the current read

    // pipeline stages
    logic              r_alu_start;
    logic [ADDR_W-1:0] r_s2_addr;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    // registered status outputs and their next values
    logic              r_rd_en;
    logic              r_done;
    logic              r_cmd_ready;
    logic              r_busy;
    logic              w_rd_en_nxt;
    logic              w_done_nxt;
    logic              w_cmd_ready_nxt;
    logic              w_busy_nxt;

    logic              w_accept;

    assign w_accept = (r_state == c_IDLE) && cmd_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: zero-length commands skip straight to DONE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (cmd_valid) w_state_nxt = (cmd_len != '0) ? c_RUN : c_DONE;
            c_RUN:   if (r_remain == '0) w_state_nxt = c_DRAIN;
            c_DRAIN: if (r_drain) w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Output decode: next values of the registered status strobes
    always_comb begin
        w_rd_en_nxt     = (w_state_nxt == c_RUN);
        w_done_nxt      = (w_state_nxt == c_DONE);
        w_cmd_ready_nxt = (w_state_nxt == c_IDLE);
        w_busy_nxt      = (w_state_nxt != c_IDLE);
    end

    // Status output registers; ready is asserted straight out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_en     <= 1'b0;
            r_done      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_rd_en     <= w_rd_en_nxt;
            r_done      <= w_done_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Command context: latch on accept, advance addresses per issued read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= '0;
            r_remain   <= '0;
            r_drain    <= 1'b0;
            r_rd_addr0 <= '0;
            r_rd_addr1 <= '0;
            r_rd_dst   <= '0;
        end else begin
            if (w_accept) begin
                r_op       <= cmd_opcode;
                r_remain   <= cmd_len - LEN_W'(1);
                r_rd_addr0 <= cmd_src0;
                r_rd_addr1 <= cmd_src1;
                r_rd_dst   <= cmd_dst;
            end else if (r_state == c_RUN) begin
                // address arithmetic wraps naturally at ADDR_W bits
                r_remain   <= r_remain - LEN_W'(1);
                r_rd_addr0 <= r_rd_addr0 + ADDR_W'(1);
                r_rd_addr1 <= r_rd_addr1 + ADDR_W'(1);
                r_rd_dst   <= r_rd_dst + ADDR_W'(1);
            end else if (r_state == c_DONE) begin
                r_op <= '0;
            end
            r_drain <= (r_state == c_DRAIN) && !r_drain;
        end
    end

    // Element pipeline: read -> ALU issue -> write-back register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_start <= 1'b0;
            r_s2_addr   <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_alu_start <= r_rd_en;
            if (r_rd_en) begin
                r_s2_addr <= r_rd_dst;
            end
            r_wr_en <= r_alu_start;
            if (r_alu_start) begin
                r_wr_addr <= r_s2_addr;
                r_wr_data <= alu_result;
            end
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign busy         = r_busy;
    assign done         = r_done;
    assign rd_en        = r_rd_en;
    assign rd_addr0     = r_rd_addr0;
    assign rd_addr1     = r_rd_addr1;
    assign alu_start    = r_alu_start;
    assign alu_opcode   = r_op;
    // read data is only meaningful in the cycle after a read strobe
    assign alu_operand0 = r_alu_start ? rd_data0 : '0;
    assign alu_operand1 = r_alu_start ? rd_data1 : '0;
    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_vpu_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vpu_stream_ctrl
// Brief    : Self-checking bench for vpu_stream_ctrl with a buffer model,
//            a behavioural FP32 ALU stand-in and a per-cycle reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vpu_stream_ctrl;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_opcode = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [ADDR_W-1:0] cmd_src0 = '0;
    logic [ADDR_W-1:0] cmd_src1 = '0;
    logic [ADDR_W-1:0] cmd_dst = '0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr0;
    logic [ADDR_W-1:0] rd_addr1;
    logic [DATA_W-1:0] rd_data0 = '0;
    logic [DATA_W-1:0] rd_data1 = '0;
    logic              alu_start;
    logic [OP_W-1:0]   alu_opcode;
    logic [DATA_W-1:0] alu_operand0;
    logic [DATA_W-1:0] alu_operand1;
    logic [DATA_W-1:0] alu_result;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              done;
    logic              busy;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    vpu_stream_ctrl #(
        .DATA_W(DATA_W), .OP_W(OP_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_len(cmd_len), .cmd_src0(cmd_src0), .cmd_src1(cmd_src1), .cmd_dst(cmd_dst),
        .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .alu_start(alu_start), .alu_opcode(alu_opcode),
        .alu_operand0(alu_operand0), .alu_operand1(alu_operand1), .alu_result(alu_result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(done), .busy(busy)
    );

    // ---------------- FP32 helpers (normal numbers and zero only) ----------
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'({3'b000, f[30:23]}) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return 32'd0;
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    // Behavioural ALU stand-in: ADD, SUB, RELU, anything else yields 0
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            4'd0:    return r2f(f2r(a) + f2r(b));
            4'd1:    return r2f(f2r(a) - f2r(b));
            4'd2:    return a[31] ? 32'd0 : a;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_opcode, alu_operand0, alu_operand1);

    // ---------------- vector buffer model: 1-cycle read latency ------------
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data0 <= mem[rd_addr0];
            rd_data1 <= mem[rd_addr1];
        end else begin
            rd_data0 <= $urandom;
            rd_data1 <= $urandom;
        end
    end

    // ---------------- per-cycle observations of one command ----------------
    logic        ob_rd   [0:63];
    logic [9:0]  ob_ra0  [0:63];
    logic [9:0]  ob_ra1  [0:63];
    logic        ob_st   [0:63];
    logic [31:0] ob_o0   [0:63];
    logic [31:0] ob_o1   [0:63];
    logic [3:0]  ob_op   [0:63];
    logic        ob_wr   [0:63];
    logic [9:0]  ob_wa   [0:63];
    logic [31:0] ob_wd   [0:63];
    logic        ob_done [0:63];
    logic        ob_rdy  [0:63];
    logic        ob_busy [0:63];

    // Issue one command and record cycles 1..ncyc (cycle 0 = accept edge)
    task automatic run_cmd(input logic [3:0] op, input logic [9:0] len, input logic [9:0] s0,
                           input logic [9:0] s1, input logic [9:0] d, input int ncyc,
                           input bit hold);
        int w;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_wait: cmd_ready=%b required 1 within 100 cycles", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_opcode = op; cmd_len = len;
        cmd_src0 = s0; cmd_src1 = s1; cmd_dst = d;
        @(posedge clk);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            ob_rd[k] = rd_en;  ob_ra0[k] = rd_addr0; ob_ra1[k] = rd_addr1;
            ob_st[k] = alu_start; ob_o0[k] = alu_operand0; ob_o1[k] = alu_operand1;
            ob_op[k] = alu_opcode;
            ob_wr[k] = wr_en;  ob_wa[k] = wr_addr; ob_wd[k] = wr_data;
            ob_done[k] = done; ob_rdy[k] = cmd_ready; ob_busy[k] = busy;
            if (hold && k < ncyc) begin
                // keep a garbage command pending; it must be ignored while busy
                cmd_opcode = 4'($urandom); cmd_len = 10'($urandom);
                cmd_src0 = 10'($urandom); cmd_src1 = 10'($urandom); cmd_dst = 10'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
    endtask

    // ---------------- scenarios --------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({cmd_ready, busy, rd_en, alu_start, wr_en, done} !== 6'b100000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: ready,busy,rd,start,wr,done=%b required 100000",
                     {cmd_ready, busy, rd_en, alu_start, wr_en, done});
        end
        tests_run++;
        if (alu_opcode !== 4'd0 || alu_operand0 !== 32'd0 || alu_operand1 !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_alu: op=%h opd0=%h opd1=%h required 0", alu_opcode,
                     alu_operand0, alu_operand1);
        end
        tests_run++;
        if (wr_addr !== 10'd0 || wr_data !== 32'd0 || rd_addr0 !== 10'd0 || rd_addr1 !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_data: wa=%h wd=%h ra0=%h ra1=%h required 0", wr_addr, wr_data,
                     rd_addr0, rd_addr1);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        for (int i = 0; i < 4; i++) begin
            mem[i] = 32'h3F800000;
            mem[10'h100 + i] = 32'h40000000;
        end
        run_cmd(4'd0, 10'd4, 10'h000, 10'h100, 10'h200, 8, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            logic ew;
            logic [9:0] ea;
            ew = (k >= 3 && k <= 6);
            ea = 10'(32'h200 + k - 3);
            tests_run++;
            if (ob_wr[k] !== ew || (ew && (ob_wa[k] !== ea || ob_wd[k] !== 32'h40400000))) begin
                tests_failed++;
                $display("FAIL add_write c%0d: wr_en=%b addr=%h data=%h required wr_en=%b addr=%h data=40400000",
                         k, ob_wr[k], ob_wa[k], ob_wd[k], ew, ea);
            end
            tests_run++;
            if (ob_rd[k] !== (k <= 4) || ob_done[k] !== (k == 7) || ob_rdy[k] !== (k == 8)) begin
                tests_failed++;
                $display("FAIL add_ctrl c%0d: rd,done,ready=%b%b%b required %b%b%b", k, ob_rd[k],
                         ob_done[k], ob_rdy[k], k <= 4, k == 7, k == 8);
            end
        end
    endtask

    task automatic test_sub();
        for (int i = 0; i < 2; i++) begin
            mem[10'h010 + i] = 32'h40400000;
            mem[10'h020 + i] = 32'h3F800000;
        end
        run_cmd(4'd1, 10'd2, 10'h010, 10'h020, 10'h030, 6, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tests_run++;
            if (ob_op[k] !== 4'd1) begin
                tests_failed++;
                $display("FAIL sub_opcode c%0d: alu_opcode=%h required 1", k, ob_op[k]);
            end
        end
        for (int k = 3; k <= 4; k++) begin
            tests_run++;
            if (ob_wr[k] !== 1'b1 || ob_wa[k] !== 10'(32'h030 + k - 3) || ob_wd[k] !== 32'h40000000) begin
                tests_failed++;
                $display("FAIL sub_write c%0d: wr_en=%b addr=%h data=%h required 1 %h 40000000",
                         k, ob_wr[k], ob_wa[k], ob_wd[k], 10'(32'h030 + k - 3));
            end
        end
    endtask

    task automatic test_relu();
        logic [31:0] src [0:2];
        logic [31:0] exp_w [0:2];
        src[0] = 32'hBF800000; src[1] = 32'h40000000; src[2] = 32'h80000000;
        exp_w[0] = 32'd0; exp_w[1] = 32'h40000000; exp_w[2] = 32'd0;
        for (int i = 0; i < 3; i++) begin
            mem[10'h040 + i] = src[i];
            mem[10'h060 + i] = $urandom;
        end
        run_cmd(4'd2, 10'd3, 10'h040, 10'h060, 10'h080, 7, 1'b0);
        for (int j = 0; j < 3; j++) begin
            tests_run++;
            if (ob_wr[j+3] !== 1'b1 || ob_wa[j+3] !== 10'(32'h080 + j) || ob_wd[j+3] !== exp_w[j]) begin
                tests_failed++;
                $display("FAIL relu_write e%0d: wr_en=%b addr=%h data=%h required 1 %h %h", j,
                         ob_wr[j+3], ob_wa[j+3], ob_wd[j+3], 10'(32'h080 + j), exp_w[j]);
            end
            tests_run++;
            if (ob_st[j+2] !== 1'b1 || ob_o1[j+2] !== mem[10'h060 + j]) begin
                tests_failed++;
                $display("FAIL relu_src1 e%0d: start=%b operand1=%h required 1 %h", j,
                         ob_st[j+2], ob_o1[j+2], mem[10'h060 + j]);
            end
        end
    endtask

    task automatic test_len0();
        run_cmd(4'd0, 10'd0, 10'h111, 10'h222, 10'h333, 4, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tests_run++;
            if (ob_done[k] !== (k == 1) || ob_rdy[k] !== (k >= 2) || ob_busy[k] !== (k == 1) ||
                ob_rd[k] !== 1'b0 || ob_st[k] !== 1'b0 || ob_wr[k] !== 1'b0) begin
                tests_failed++;
                $display("FAIL len0 c%0d: done,ready,busy,rd,start,wr=%b%b%b%b%b%b required %b%b%b000",
                         k, ob_done[k], ob_rdy[k], ob_busy[k], ob_rd[k], ob_st[k], ob_wr[k],
                         k == 1, k >= 2, k == 1);
            end
        end
    endtask

    task automatic test_wrap();
        logic [9:0] ra [0:2];
        logic [9:0] wa [0:2];
        logic [31:0] ed;
        ra[0] = 10'h3FE; ra[1] = 10'h3FF; ra[2] = 10'h000;
        wa[0] = 10'h3FF; wa[1] = 10'h000; wa[2] = 10'h001;
        for (int j = 0; j < 3; j++) begin
            mem[ra[j]] = r2f(real'(j + 5));
            mem[10'h050 + j] = r2f(real'(j + 1));
        end
        run_cmd(4'd0, 10'd3, 10'h3FE, 10'h050, 10'h3FF, 7, 1'b0);
        for (int j = 0; j < 3; j++) begin
            tests_run++;
            if (ob_rd[j+1] !== 1'b1 || ob_ra0[j+1] !== ra[j] || ob_ra1[j+1] !== 10'(32'h050 + j)) begin
                tests_failed++;
                $display("FAIL wrap_read e%0d: rd=%b a0=%h a1=%h required 1 %h %h", j, ob_rd[j+1],
                         ob_ra0[j+1], ob_ra1[j+1], ra[j], 10'(32'h050 + j));
            end
            ed = alu_fn(4'd0, mem[ra[j]], mem[10'h050 + j]);
            tests_run++;
            if (ob_wr[j+3] !== 1'b1 || ob_wa[j+3] !== wa[j] || ob_wd[j+3] !== ed) begin
                tests_failed++;
                $display("FAIL wrap_write e%0d: wr=%b addr=%h data=%h required 1 %h %h", j,
                         ob_wr[j+3], ob_wa[j+3], ob_wd[j+3], wa[j], ed);
            end
        end
    endtask

    task automatic test_reset_mid();
        int w;
        logic ew;
        for (int i = 0; i < 8; i++) begin
            mem[i] = 32'h3F800000;
            mem[10'h100 + i] = 32'h40000000;
        end
        for (int i = 0; i < 2; i++) begin
            mem[10'h300 + i] = 32'h40400000;
            mem[10'h310 + i] = 32'h3F800000;
        end
        w = 0;
        while (cmd_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rmid_idle_wait: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_opcode = 4'd0; cmd_len = 10'd8;
        cmd_src0 = 10'h000; cmd_src1 = 10'h100; cmd_dst = 10'h200;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 4) begin
                tests_run++;
                if (wr_en !== 1'b1 || wr_addr !== 10'h201 || wr_data !== 32'h40400000) begin
                    tests_failed++;
                    $display("FAIL rmid_c4_write: wr=%b addr=%h data=%h required 1 201 40400000",
                             wr_en, wr_addr, wr_data);
                end
                rst = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if ({cmd_ready, busy, rd_en, alu_start, wr_en, done} !== 6'b100000) begin
            tests_failed++;
            $display("FAIL rmid_c5_state: ready,busy,rd,start,wr,done=%b required 100000",
                     {cmd_ready, busy, rd_en, alu_start, wr_en, done});
        end
        // new command presented while cmd_valid stays high; accepted on the cycle-5 edge
        cmd_opcode = 4'd1; cmd_len = 10'd2;
        cmd_src0 = 10'h300; cmd_src1 = 10'h310; cmd_dst = 10'h320;
        @(posedge clk);
        for (int k = 6; k <= 11; k++) begin
            @(negedge clk);
            if (k == 6) begin
                cmd_valid = 1'b0;
                tests_run++;
                if (busy !== 1'b1 || rd_en !== 1'b1 || rd_addr0 !== 10'h300) begin
                    tests_failed++;
                    $display("FAIL rmid_new_accept: busy=%b rd=%b a0=%h required 1 1 300",
                             busy, rd_en, rd_addr0);
                end
            end
            ew = (k == 8 || k == 9);
            tests_run++;
            if (wr_en !== ew || (ew && (wr_addr !== 10'(32'h320 + k - 8) || wr_data !== 32'h40000000))) begin
                tests_failed++;
                $display("FAIL rmid_write c%0d: wr=%b addr=%h data=%h required %b %h 40000000",
                         k, wr_en, wr_addr, wr_data, ew, 10'(32'h320 + k - 8));
            end
            tests_run++;
            if (done !== (k == 10)) begin
                tests_failed++;
                $display("FAIL rmid_done c%0d: done=%b required %b", k, done, k == 10);
            end
        end
    endtask

    task automatic test_random();
        for (int a = 0; a < 1024; a++) mem[a] = r2f(real'($urandom_range(200, 0)) - 100.0);
        for (int it = 0; it < 12; it++) begin
            logic [3:0] op;
            logic [9:0] len, s0, s1, d;
            bit hold;
            int nc, dc, n;
            op   = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 3)) : 4'($urandom_range(2, 0));
            len  = (it == 0) ? 10'd0 : 10'($urandom_range(20, 1));
            s0   = 10'($urandom); s1 = 10'($urandom); d = 10'($urandom);
            hold = 1'($urandom_range(1, 0));
            n    = int'(len);
            dc   = (n == 0) ? 1 : n + 3;
            nc   = dc + 1;
            run_cmd(op, len, s0, s1, d, nc, hold);
            for (int k = 1; k <= nc; k++) begin
                logic e_rd, e_st, e_wr;
                logic [9:0] ea0, ea1, ewa;
                logic [31:0] eo0, eo1, ewd;
                e_rd = (k <= n);
                e_st = (k >= 2 && k <= n + 1);
                e_wr = (k >= 3 && k <= n + 2);
                ea0  = s0 + 10'(k - 1);
                ea1  = s1 + 10'(k - 1);
                eo0  = e_st ? mem[s0 + 10'(k - 2)] : 32'd0;
                eo1  = e_st ? mem[s1 + 10'(k - 2)] : 32'd0;
                ewa  = d + 10'(k - 3);
                ewd  = alu_fn(op, mem[s0 + 10'(k - 3)], mem[s1 + 10'(k - 3)]);
                tests_run++;
                if (ob_rd[k] !== e_rd || (e_rd && (ob_ra0[k] !== ea0 || ob_ra1[k] !== ea1))) begin
                    tests_failed++;
                    $display("FAIL rand%0d_read c%0d: rd=%b a0=%h a1=%h required %b %h %h", it, k,
                             ob_rd[k], ob_ra0[k], ob_ra1[k], e_rd, ea0, ea1);
                end
                tests_run++;
                if (ob_st[k] !== e_st || ob_o0[k] !== eo0 || ob_o1[k] !== eo1) begin
                    tests_failed++;
                    $display("FAIL rand%0d_alu c%0d: start=%b opd0=%h opd1=%h required %b %h %h", it, k,
                             ob_st[k], ob_o0[k], ob_o1[k], e_st, eo0, eo1);
                end
                tests_run++;
                if (ob_wr[k] !== e_wr || (e_wr && (ob_wa[k] !== ewa || ob_wd[k] !== ewd))) begin
                    tests_failed++;
                    $display("FAIL rand%0d_write c%0d: wr=%b addr=%h data=%h required %b %h %h", it, k,
                             ob_wr[k], ob_wa[k], ob_wd[k], e_wr, ewa, ewd);
                end
                tests_run++;
                if (ob_done[k] !== (k == dc) || ob_rdy[k] !== (k == nc) || ob_busy[k] !== (k != nc)) begin
                    tests_failed++;
                    $display("FAIL rand%0d_status c%0d: done,ready,busy=%b%b%b required %b%b%b", it, k,
                             ob_done[k], ob_rdy[k], ob_busy[k], k == dc, k == nc, k != nc);
                end
                if (k <= dc) begin
                    tests_run++;
                    if (ob_op[k] !== op) begin
                        tests_failed++;
                        $display("FAIL rand%0d_opcode c%0d: alu_opcode=%h required %h", it, k,
                                 ob_op[k], op);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_relu();
        test_len0();
        test_wrap();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vpu_stream_ctrl.md
# vpu_stream_ctrl

Sequencer sitting directly upstream of the VPU ALU stage (`vpu_op`). Accepts one vector command (opcode, length, two source addresses, one destination address), streams element pairs from a dual-read vector buffer into the ALU at one element per cycle, registers each ALU result, and writes it back to the buffer. Signals completion with a one-cycle `done` pulse. Fixed latency, no backpressure.

## Interface
- `DATA_W`, 32, element width (FP32 bit pattern)
- `OP_W`, 4, opcode width (0 ADD, 1 SUB, 2 RELU, others pass through)
- `ADDR_W`, 10, buffer address width
- `LEN_W`, 10, element count width
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  high only in IDLE
- `cmd_opcode`  in  OP_W  operation
- `cmd_len`  in  LEN_W  element count, 0 allowed
- `cmd_src0`, `cmd_src1`, `cmd_dst`  in  ADDR_W  base addresses
- `rd_en`  out  1  buffer read strobe; data returns exactly 1 cycle later
- `rd_addr0`, `rd_addr1`  out  ADDR_W  read addresses
- `rd_data0`, `rd_data1`  in  DATA_W  read data
- `alu_start`  out  1  ALU `start`
- `alu_opcode`  out  OP_W  ALU `opcode`
- `alu_operand0`, `alu_operand1`  out  DATA_W  ALU operands
- `alu_result`  in  DATA_W  ALU `result_out` (combinational)
- `wr_en`  out  1  buffer write strobe
- `wr_addr`  out  ADDR_W  write address
- `wr_data`  out  DATA_W  write data
- `done`  out  1  one-cycle completion pulse
- `busy`  out  1  high in any state except IDLE

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid` at clk edge, latch opcode/len/src0/src1/dst; go RUN if len>0, else DONE.
- RUN: `rd_en`=1 each cycle, addresses = src0+i, src1+i, i = 0..len-1. After issuing i=len-1 go DRAIN.
- Stage 2 (cycle after each read): `alu_start`=1, `alu_operand0/1` = `rd_data0/1`, `alu_opcode` = latched opcode; `alu_result` captured into write register with address dst+i.
- Stage 3: `wr_en`=1, `wr_addr`/`wr_data` from write register.
- DRAIN: no reads; remains until last write has been presented (2 cycles), then DONE.
- DONE: `done`=1 for one cycle, `cmd_ready`=0; next cycle IDLE.
- `alu_opcode` holds latched opcode from accept until return to IDLE; 0 in IDLE after reset. `alu_operand0/1` = 0 whenever `alu_start`=0.
- Address arithmetic modulo 2^ADDR_W (wraps from all-ones to 0, no error).
- Opcodes >2 executed normally; the ALU returns 0, so 0 is written.
- Both sources always read, including RELU (operand1 ignored by ALU).
- Reset: all outputs 0 on the cycle after the reset edge (`cmd_ready`=1 once in IDLE), state IDLE, in-flight reads/writes discarded, no `done`. Reset mid-command aborts with no further writes.
- `cmd_valid` outside IDLE ignored; commands never queued.

## Timing
- Accept edge = cycle 0. Element i: `rd_en` cycle 1+i, `alu_start` cycle 2+i, `wr_en` cycle 3+i.
- len=N>0: writes cycles 3..N+2, `done` cycle N+3, `cmd_ready` high again cycle N+4.
- len=0: `done` cycle 1, `cmd_ready` cycle 2; no `rd_en`/`alu_start`/`wr_en`.
- Throughput 1 element/cycle; back-to-back commands separated by N+4 cycles.
- `rd_en`, `wr_en`, `done`, `cmd_ready`, `busy`, `wr_addr`, `wr_data` are registered; `alu_operand*`/`alu_start` are registered control gating registered-next-cycle `rd_data`.

## Test plan
- ADD N=4, src0=0x000, src1=0x100, dst=0x200, buffers hold 1.0f/2.0f (0x3F800000/0x40000000) -> four writes of 0x40400000 at 0x200..0x203 in cycles 3..6, `done` cycle 7.
- SUB N=2 of 3.0f−1.0f -> `alu_opcode`=1 throughout, writes carry ALU result, addresses dst, dst+1.
- RELU N=3 with src0 = {0xBF800000, 0x40000000, 0x80000000} -> writes {0, 0x40000000, 0}.
- len=0 -> `done` in cycle 1, zero `rd_en`/`wr_en` pulses, `cmd_ready` back in cycle 2.
- src0=0x3FE, dst=0x3FF, N=3 -> reads 0x3FE,0x3FF,0x000; writes 0x3FF,0x000,0x001.
- `rst` asserted in cycle 4 of an N=8 ADD, with `cmd_valid` held high across it -> no `wr_en` after cycle 4, no `done`, IDLE/`cmd_ready`=1 in cycle 5, a fresh command accepted on the cycle-5 edge.
